// File: rtl/pio_irq_debounce_if.sv
// Avalon-MM slave bus bundle for the pio_irq_debounce peripheral.
interface pio_irq_debounce_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/pio_irq_debounce.sv
// Avalon-MM PIO: synchronised, debounced inputs with edge capture and masked irq; set/clear outputs.
// Optional feature macro: PIO_DEBOUNCE_EN (per-bit debounce counters; otherwise stable follows sync).
module pio_irq_debounce #(
  parameter int unsigned          IN_WIDTH        = 4,
  parameter int unsigned          OUT_WIDTH       = 32,
  parameter int unsigned          DEBOUNCE_CYCLES = 50000,
  parameter int unsigned          EDGE_MODE       = 2,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  pio_irq_debounce_if.slave    avs,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA_IN  = 3'd0;
  localparam logic [2:0] A_DATA_OUT = 3'd1;
  localparam logic [2:0] A_IRQ_MASK = 3'd2;
  localparam logic [2:0] A_EDGE_CAP = 3'd3;
  localparam logic [2:0] A_OUT_SET  = 3'd4;
  localparam logic [2:0] A_OUT_CLR  = 3'd5;

  typedef enum logic [1:0] {PRIME0, PRIME1, PRIME2, RUN} state_e;

  state_e state_q, state_d;
  logic   run_c, prime_load_c;

  logic [IN_WIDTH-1:0]  sync1_q, sync_q;
  logic [IN_WIDTH-1:0]  stable_q, stable_d;
  logic [IN_WIDTH-1:0]  mask_q, mask_d;
  logic [IN_WIDTH-1:0]  cap_q, cap_d;
  logic [IN_WIDTH-1:0]  edge_set_c, cap_clr_c, rise_c, fall_c;
  logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [IN_WIDTH-1:0]  wdata_in_c;
  logic [OUT_WIDTH-1:0] wdata_out_c;
  logic                 unused_wdata_c;

  // Priming sequencer state register
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state_q <= PRIME0;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    run_c        = 1'b0;
    prime_load_c = 1'b0;
    case (state_q)
      PRIME0:  state_d = PRIME1;
      PRIME1:  state_d = PRIME2;
      PRIME2: begin
        state_d      = RUN;
        prime_load_c = 1'b1;
      end
      RUN:     run_c = 1'b1;
      default: state_d = PRIME0;
    endcase
  end

  // Two-flop synchroniser
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= in_port;
      sync_q  <= sync1_q;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [IN_WIDTH];
  logic [CNT_W-1:0] cnt_d [IN_WIDTH];

  // A bit is accepted only after sync has differed from stable for DEBOUNCE_CYCLES clocks
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      cnt_d[i] = '0;
      if (run_c && (sync_q[i] != stable_q[i])) begin
        if (cnt_q[i] == CNT_MAX) stable_d[i] = sync_q[i];
        else                     cnt_d[i]    = cnt_q[i] + CNT_W'(1);
      end
    end
    if (prime_load_c) stable_d = sync_q;
  end

  always_ff @(posedge clk_clk) begin
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      if (!reset_reset_n) cnt_q[i] <= '0;
      else                cnt_q[i] <= cnt_d[i];
    end
  end
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  always_comb begin
    stable_d = stable_q;
    if (run_c || prime_load_c) stable_d = sync_q;
  end
`endif

  // Edges are only recognised once running; the priming load never captures
  always_comb begin
    rise_c = run_c ? (stable_d & ~stable_q) : '0;
    fall_c = run_c ? (~stable_d & stable_q) : '0;
    if (EDGE_MODE == 0)      edge_set_c = rise_c;
    else if (EDGE_MODE == 1) edge_set_c = fall_c;
    else                     edge_set_c = rise_c | fall_c;
  end

  assign wdata_in_c     = avs.avs_writedata[IN_WIDTH-1:0];
  assign wdata_out_c    = avs.avs_writedata[OUT_WIDTH-1:0];
  assign unused_wdata_c = ^avs.avs_writedata;

  // Register writes and read-data capture
  always_comb begin
    data_out_d = data_out_q;
    mask_d     = mask_q;
    cap_clr_c  = '0;
    rdata_d    = rdata_q;
    if (avs.avs_write) begin
      case (avs.avs_address)
        A_DATA_OUT: data_out_d = wdata_out_c;
        A_IRQ_MASK: mask_d     = wdata_in_c;
        A_EDGE_CAP: cap_clr_c  = wdata_in_c;
        A_OUT_SET:  data_out_d = data_out_q | wdata_out_c;
        A_OUT_CLR:  data_out_d = data_out_q & ~wdata_out_c;
        default:    ;
      endcase
    end
    if (avs.avs_read) begin
      case (avs.avs_address)
        A_DATA_IN:  rdata_d = 32'(stable_q);
        A_DATA_OUT: rdata_d = 32'(data_out_q);
        A_IRQ_MASK: rdata_d = 32'(mask_q);
        A_EDGE_CAP: rdata_d = 32'(cap_q);
        default:    rdata_d = '0;
      endcase
    end
    // A new edge beats a simultaneous write-1-to-clear
    cap_d = (cap_q & ~cap_clr_c) | edge_set_c;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      stable_q   <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      data_out_q <= OUT_RESET;
      rdata_q    <= '0;
    end else begin
      stable_q   <= stable_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      data_out_q <= data_out_d;
      rdata_q    <= rdata_d;
    end
  end

  assign irq              = |(cap_q & mask_q);
  assign out_port         = data_out_q;
  assign avs.avs_readdata = rdata_q;

endmodule
